spm_responder: RTL and testbench
================================

Name: spm_responder

Overview:
Target-side responder for the SPM bus that the memory-stage bus interface drives. It accepts word accesses on spm_addr, spm_as_, spm_rw and spm_wr_data, and serves them from an internal word-addressed scratchpad array. Each access completes after a configurable number of wait states, signalled by a one-cycle active-low ready strobe. Out-of-range accesses are reported on an error flag. The block is the memory end of the SPM link and later replaces the bench-driven spm_rd_data.

Parameters:
ADDR_LOG2, 12, log2 of array depth in words (depth 4096 words = 16 KiB)
WAIT_CYCLES, 1, wait states between request capture and the response cycle (legal 0..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
spm_addr  in  30  word address (byte address >> 2)
spm_as_  in  1  address strobe, active-low (0 = request)
spm_rw  in  1  1 = read, 0 = write
spm_wr_data  in  32  write data
spm_rd_data  out  32  read data, valid during the response cycle, held afterwards
spm_rdy_  out  1  response strobe, active-low, one cycle per access
spm_err  out  1  out-of-range flag, valid with spm_rdy_ low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: spm_rd_data = 0, spm_rdy_ = 1, spm_err = 0, FSM = IDLE, wait counter = 0.
- Reset does not clear the array. Array contents are undefined after power-up.
- Protocol: the initiator drives spm_as_ = 0 and holds addr/rw/wr_data stable until it sees spm_rdy_ = 0. It may start a new request from the cycle after the response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If spm_as_ = 0 at the edge, latch addr, rw and wr_data, and clear the counter.
  - Go to WAIT if WAIT_CYCLES > 0, otherwise go to RESP.
- WAIT:
  - Counter increments each cycle.
  - When counter = WAIT_CYCLES-1, go to RESP.
  - spm_as_ is ignored in this state.
- RESP:
  - spm_rdy_ = 0 for exactly this cycle.
  - Next state is always IDLE. spm_as_ is not sampled in RESP, so there is a minimum 1-cycle gap between accesses.
- Latency: the request is sampled at edge N. spm_rdy_ is low in cycle N+1+WAIT_CYCLES.
  - Total occupancy per access is WAIT_CYCLES+2 cycles including the IDLE sample.
- Range check: the access is in range when latched addr[29:ADDR_LOG2] == 0.
- In-range write:
  - The array word is written at the edge that enters RESP.
  - spm_err = 0.
  - spm_rd_data is unchanged.
- In-range read:
  - spm_rd_data is loaded with array[addr] at the edge entering RESP, so it is valid while spm_rdy_ = 0.
  - The value is held until the next read response.
- Out-of-range access:
  - spm_err = 1 during RESP and 0 otherwise.
  - No array write.
  - Read returns spm_rd_data = 0.
- Read after write to the same address returns the new data. No bypassing is needed because accesses are serialized.
- Input changes during WAIT or RESP have no effect, because only the latched copies are used.
- Reset mid-access (in WAIT or RESP before the edge): the access is aborted and the pending write is not committed. The FSM goes to IDLE and no spm_rdy_ strobe is produced.
- Reset has priority over all other events at the same edge.
- If WAIT_CYCLES is out of range (> 7), the value saturates to 7.

Test Plan:
1. WAIT_CYCLES=1: write 0x24 to addr 0x55 (as_=0, rw=0) at edge N -> spm_rdy_=0 only in cycle N+2, spm_err=0. Then read addr 0x55 -> spm_rd_data=0x24 while spm_rdy_=0, and held at 0x24 afterwards.
2. WAIT_CYCLES=0: back-to-back writes 0x11 to 0x10 and 0x22 to 0x11, then reads of both -> each rdy_ strobe comes 1 cycle after capture, with a 1-cycle gap between accesses. Reads return 0x11 and 0x22.
3. Out-of-range: read addr 0x1000 with ADDR_LOG2=12 -> spm_err=1 and spm_rd_data=0 during spm_rdy_=0. Write 0xDEAD to 0x1000, then read 0x000 -> array word 0 unchanged.
4. WAIT_CYCLES=3: hold a write request, then change spm_wr_data to 0xBAD during WAIT -> the latched original 0x77 is stored, and a readback returns 0x77. A spm_as_ pulse during WAIT creates no extra response.
5. Reset mid-write: write 0x99 to 0x20 (previously 0x24), assert reset for 1 cycle during WAIT -> no spm_rdy_ strobe, all outputs at reset values. A later read of 0x20 returns 0x24.
6. Reset while idle: all outputs are at reset values the cycle after reset. A read immediately after reset release is served normally.

Source files
------------

// File: rtl/spm_responder.sv
// SPM bus target: serves word accesses from an internal scratchpad after a
// fixed number of wait states, with a one-cycle active-low ready strobe.
module spm_responder #(
    parameter int unsigned ADDR_LOG2   = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] spm_addr,
    input  logic        spm_as_,
    input  logic        spm_rw,
    input  logic [31:0] spm_wr_data,
    output logic [31:0] spm_rd_data,
    output logic        spm_rdy_,
    output logic        spm_err
);

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 1 << ADDR_LOG2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MAX_WAIT = 7;
    localparam int unsigned WAITS    = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((WAITS == 0) ? 0 : WAITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_rw;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                capture;
    logic                enter_resp;
    logic [ADDR_W-1:0]   cur_addr;
    logic                cur_rw;
    logic [DATA_W-1:0]   cur_wdata;
    logic                in_range;
    logic [ADDR_LOG2-1:0] mem_idx;

    // With zero wait states the response edge is the capture edge, so the
    // live bus values stand in for the not-yet-latched copies.
    always_comb begin
        capture    = (state == S_IDLE) && !spm_as_;
        cur_addr   = capture ? spm_addr    : lat_addr;
        cur_rw     = capture ? spm_rw      : lat_rw;
        cur_wdata  = capture ? spm_wr_data : lat_wdata;
        enter_resp = (capture && (WAITS == 0)) ||
                     ((state == S_WAIT) && (cnt == LAST_WAIT));
        in_range   = (cur_addr >> ADDR_LOG2) == '0;
        mem_idx    = cur_addr[ADDR_LOG2-1:0];
    end

    // Array commit; a reset on the same edge aborts the pending write.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && in_range && !cur_rw) begin
            mem[mem_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            spm_rd_data <= '0;
            spm_rdy_    <= 1'b1;
            spm_err     <= 1'b0;
        end else begin
            spm_rdy_ <= ~enter_resp;
            spm_err  <= enter_resp && !in_range;
            if (enter_resp && cur_rw) begin
                spm_rd_data <= in_range ? mem[mem_idx] : '0;
            end
            case (state)
                S_IDLE: begin
                    if (!spm_as_) begin
                        lat_addr  <= spm_addr;
                        lat_rw    <= spm_rw;
                        lat_wdata <= spm_wr_data;
                        cnt       <= '0;
                        state     <= (WAITS == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_WAIT) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_responder.sv
// Randomized bench for spm_responder: four instances with different wait-state
// settings, checked against a latency rule and an associative-array memory model.
module tb_spm_responder;

    localparam int unsigned NI = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned WCS [NI] = '{0, 1, 3, 9};
    localparam int unsigned NPOOL = 11;
    localparam int unsigned NIN   = 8;
    localparam logic [29:0] POOL [NPOOL] = '{30'h000, 30'h010, 30'h011, 30'h020,
                                             30'h030, 30'h055, 30'h7FF, 30'hFFF,
                                             30'h1000, 30'h3FFFFFFF, 30'h20000000};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [NI];
    logic        as_n   [NI];
    logic        rw_a   [NI];
    logic [29:0] addr_a [NI];
    logic [31:0] wd_a   [NI];
    logic [31:0] rd_a   [NI];
    logic        rdy_a  [NI];
    logic        err_a  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spm_responder #(.ADDR_LOG2(AW), .WAIT_CYCLES(WCS[g])) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .spm_addr    (addr_a[g]),
            .spm_as_     (as_n[g]),
            .spm_rw      (rw_a[g]),
            .spm_wr_data (wd_a[g]),
            .spm_rd_data (rd_a[g]),
            .spm_rdy_    (rdy_a[g]),
            .spm_err     (err_a[g])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] model [longint];
    logic [31:0] last_rd [NI];

    task automatic check(input int d, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s wc=%0d: got 0x%08h, expected 0x%08h", tag, WCS[d], got, exp);
    endtask

    function automatic int eff_wc(input int d);
        return (WCS[d] > 7) ? 7 : int'(WCS[d]);
    endfunction

    function automatic longint key(input int d, input logic [29:0] a);
        return (longint'(d) << 32) | longint'(a);
    endfunction

    task automatic check_idle_outputs(input int d, input string tag);
        check(d, {tag, "_rdy"}, 32'(rdy_a[d]), 32'd1);
        check(d, {tag, "_err"}, 32'(err_a[d]), 32'd0);
        check(d, {tag, "_rd"},  rd_a[d], last_rd[d]);
    endtask

    // One complete access: strobe must appear exactly wc+1 edges after capture.
    task automatic access(input int d, input bit rd, input logic [29:0] a,
                          input logic [31:0] wd, input bit scramble);
        int wc;
        bit inr;
        wc  = eff_wc(d);
        inr = (a >> AW) == 0;
        @(negedge clk);
        addr_a[d] = a; rw_a[d] = rd; wd_a[d] = wd; as_n[d] = 1'b0;
        for (int k = 0; k < wc; k++) begin
            @(posedge clk); #1;
            check(d, "wait_rdy", 32'(rdy_a[d]), 32'd1);
            if (scramble) begin
                addr_a[d] = 30'($urandom); wd_a[d] = 32'hBAD;
                rw_a[d] = 1'($urandom); as_n[d] = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        as_n[d] = 1'b1; wd_a[d] = $urandom; addr_a[d] = 30'($urandom);
        if (rd) last_rd[d] = inr ? model[key(d, a)] : 32'd0;
        else if (inr) model[key(d, a)] = wd;
        check(d, "resp_rdy", 32'(rdy_a[d]), 32'd0);
        check(d, "resp_err", 32'(err_a[d]), inr ? 32'd0 : 32'd1);
        check(d, "resp_rd",  rd_a[d], last_rd[d]);
        @(posedge clk); #1;
        check_idle_outputs(d, "after");
    endtask

    task automatic reset_mid(input int d, input logic [29:0] a, input logic [31:0] wd);
        int wc;
        wc = eff_wc(d);
        @(negedge clk);
        addr_a[d] = a; rw_a[d] = 1'b0; wd_a[d] = wd; as_n[d] = 1'b0;
        @(posedge clk); #1;
        rst[d] = 1'b1; as_n[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        last_rd[d] = 32'd0;
        check_idle_outputs(d, "rst_mid");
        for (int k = 0; k < wc + 2; k++) begin
            @(posedge clk); #1;
            check(d, "rst_mid_norsp", 32'(rdy_a[d]), 32'd1);
        end
    endtask

    task automatic reset_idle(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        last_rd[d] = 32'd0;
        check_idle_outputs(d, "rst_idle");
    endtask

    initial begin
        for (int d = 0; d < NI; d++) begin
            rst[d] = 1'b1; as_n[d] = 1'b1; rw_a[d] = 1'b0;
            addr_a[d] = '0; wd_a[d] = '0; last_rd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) check_idle_outputs(d, "por");
        for (int d = 0; d < NI; d++) rst[d] = 1'b0;

        for (int d = 0; d < NI; d++)
            for (int i = 0; i < NIN; i++) access(d, 1'b0, POOL[i], $urandom, 1'b0);

        access(1, 1'b0, 30'h055, 32'h24, 1'b0);
        access(1, 1'b1, 30'h055, 32'h0, 1'b0);

        access(0, 1'b0, 30'h010, 32'h11, 1'b0);
        access(0, 1'b0, 30'h011, 32'h22, 1'b0);
        access(0, 1'b1, 30'h010, 32'h0, 1'b0);
        access(0, 1'b1, 30'h011, 32'h0, 1'b0);

        for (int d = 0; d < NI; d++) begin
            access(d, 1'b1, 30'h1000, 32'h0, 1'b0);
            access(d, 1'b0, 30'h1000, 32'hDEAD, 1'b0);
            access(d, 1'b0, 30'h3FFFFFFF, 32'hBEEF, 1'b0);
            access(d, 1'b1, 30'h000, 32'h0, 1'b0);
        end

        access(2, 1'b0, 30'h030, 32'h77, 1'b1);
        access(2, 1'b1, 30'h030, 32'h0, 1'b0);

        for (int d = 1; d < NI; d++) begin
            access(d, 1'b0, 30'h020, 32'h24, 1'b0);
            reset_mid(d, 30'h020, 32'h99);
            access(d, 1'b1, 30'h020, 32'h0, 1'b0);
        end

        for (int d = 0; d < NI; d++) begin
            reset_idle(d);
            access(d, 1'b1, 30'h055, 32'h0, 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            int d;
            int idx;
            d   = $urandom_range(0, NI - 1);
            idx = $urandom_range(0, NPOOL - 1);
            access(d, 1'($urandom), POOL[idx], $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
